// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider: control states and the default operand width.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/addsub_nbit.sv
// Parameterised ripple-carry adder/subtractor: sum = a + (b ^ {N{m}}) + c_in.
// c_out is the final carry (no-borrow in subtract mode) and v is signed overflow.
module addsub_nbit #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         m,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         v
);

    logic [N-1:0] b_x_s;

    assign b_x_s = b ^ {N{m}};

    // Ripple the carry through each bit; keep the carry into the MSB for overflow.
    always_comb begin
        logic carry;
        logic carry_msb;
        carry     = c_in;
        carry_msb = 1'b0;
        sum       = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                carry_msb = carry;
            end else begin
                carry_msb = carry_msb;
            end
            sum[i] = a[i] ^ b_x_s[i] ^ carry;
            carry  = (a[i] & b_x_s[i]) | (carry & (a[i] ^ b_x_s[i]));
        end
        c_out = carry;
        v     = carry ^ carry_msb;
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with a
// divide-by-zero shortcut that finishes in a single cycle.
module seq_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] q_r, q_nxt_s;
    logic [WIDTH:0]   r_r, r_nxt_s;
    logic [WIDTH-1:0] div_r, div_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             dz_r, dz_nxt_s;
    logic             busy_r, done_r;

    logic [WIDTH:0]   r_sh_s;
    logic [WIDTH-1:0] q_sh_s;
    logic [WIDTH:0]   diff_s;
    logic             c_out_s;
    logic             v_unused_s;

    assign {r_sh_s, q_sh_s} = {r_r, q_r} << 1;

    addsub_nbit #(.N(WIDTH + 1)) u_addsub (
        .a     (r_sh_s),
        .b     ({1'b0, div_r}),
        .c_in  (1'b1),
        .m     (1'b1),
        .sum   (diff_s),
        .c_out (c_out_s),
        .v     (v_unused_s)
    );

    // Next-state and datapath update for the accept / iterate / report sequence.
    always_comb begin
        state_nxt_s = state_r;
        q_nxt_s     = q_r;
        r_nxt_s     = r_r;
        div_nxt_s   = div_r;
        cnt_nxt_s   = cnt_r;
        dz_nxt_s    = dz_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (divisor != {WIDTH{1'b0}}) begin
                        div_nxt_s   = divisor;
                        q_nxt_s     = dividend;
                        r_nxt_s     = {(WIDTH + 1){1'b0}};
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        dz_nxt_s    = 1'b0;
                        state_nxt_s = RUN;
                    end else begin
                        q_nxt_s     = {WIDTH{1'b1}};
                        r_nxt_s     = {1'b0, dividend};
                        dz_nxt_s    = 1'b1;
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
                // c_out high means no borrow: the trial subtraction is kept.
                if (c_out_s) begin
                    r_nxt_s = diff_s;
                end else begin
                    r_nxt_s = r_sh_s;
                end
                q_nxt_s = q_sh_s | {{(WIDTH - 1){1'b0}}, c_out_s};
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            q_r     <= {WIDTH{1'b0}};
            r_r     <= {(WIDTH + 1){1'b0}};
            div_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            dz_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            q_r     <= q_nxt_s;
            r_r     <= r_nxt_s;
            div_r   <= div_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dz_r    <= dz_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = q_r;
    assign remainder = r_r[WIDTH-1:0];
    assign dz        = dz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): directed scenarios, random
// operands and an exhaustive sweep against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dz;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_q(input logic [W-1:0] a, input logic [W-1:0] b);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) return {W{1'b1}};
        return W'(ai / bi);
    endfunction

    function automatic logic [W-1:0] ref_r(input logic [W-1:0] a, input logic [W-1:0] b);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) return a;
        return W'(ai % bi);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at a negedge in IDLE
    // so that consecutive calls run back to back.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        int busy_cnt;
        logic [W-1:0] eq, er;
        eq = ref_q(a, b);
        er = ref_r(a, b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat      = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 3 * W) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check("done_seen", done, 1);
        check("latency", lat, (b == 0) ? 1 : W + 1);
        check("busy_cycles", busy_cnt, (b == 0) ? 0 : W);
        check("busy_at_done", busy, 0);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("dz", dz, (b == 0) ? 1 : 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("quotient_hold", quotient, eq);
        check("remainder_hold", remainder, er);
    endtask

    initial begin
        int k;
        int done_seen;
        logic [W-1:0] ra, rb;
        rst_n    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2;
        rst_n = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dz", dz, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'd13, 4'd3);
        run_op(4'd15, 4'd1);
        run_op(4'd2, 4'd9);
        repeat (3) @(negedge clk);
        check("idle_hold_q", quotient, 0);
        check("idle_hold_r", remainder, 2);
        check("idle_no_done", done, 0);
        run_op(4'd7, 4'd0);
        run_op(4'd6, 4'd2);

        // Requests while busy and during the done cycle are dropped.
        dividend = 4'd9;
        divisor  = 4'd4;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dividend = 4'd15;
        divisor  = 4'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 3 * W) begin
            @(negedge clk);
            k++;
        end
        check("ign_done_seen", done, 1);
        check("ign_quotient", quotient, 2);
        check("ign_remainder", remainder, 1);
        dividend = 4'd15;
        divisor  = 4'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_no_restart_busy", busy, 0);
        check("ign_done_low", done, 0);
        done_seen = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("ign_no_second_op", done_seen, 0);
        check("ign_hold_q", quotient, 2);
        check("ign_hold_r", remainder, 1);

        // Reset in the second RUN cycle aborts the operation.
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dz", dz, 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        run_op(4'd14, 4'd3);

        repeat (40) begin
            ra = W'($urandom);
            rb = W'($urandom_range(0, 15));
            run_op(ra, rb);
        end

        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                run_op(W'(a), W'(b));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
